// File: rtl/cpu_pkg.sv
// Shared CPU datapath types and register-file constants.
// Used by the register bank, the write-destination mux and the control unit.
package cpu_pkg;

  localparam int unsigned REG_AW        = 5;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned WR_CNT_W      = 16;
  localparam int unsigned NREGS_DEFAULT = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [WORD_W-1:0] word_t;

  localparam reg_addr_t REG_ZERO         = 5'd0;
  localparam reg_addr_t REG_SP           = 5'd29;
  localparam reg_addr_t REG_RA           = 5'd31;
  localparam word_t     SP_RESET_DEFAULT = 32'd227;

  typedef struct packed {
    logic      en;
    reg_addr_t addr;
    word_t     data;
  } wr_req_t;

  // A write commits only when enabled and not aimed at $zero.
  function automatic logic wr_commits(input wr_req_t req);
    return req.en && (req.addr != REG_ZERO);
  endfunction

endpackage

// File: rtl/reg_bank_wr_counter.sv
// Wrapping committed-write counter with increment enable.
module reg_bank_wr_counter
  import cpu_pkg::*;
#(
  parameter int unsigned W = WR_CNT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/reg_bank.sv
// 32 x 32-bit register file with registered A/B read ports and $sp reset value.
// Define REG_BANK_BYPASS_EN to forward same-edge write data to colliding reads.
module reg_bank
  import cpu_pkg::*;
#(
  parameter word_t       SP_RESET = SP_RESET_DEFAULT,
  parameter int unsigned NREGS    = NREGS_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                rd_en,
  input  logic [REG_AW-1:0]   rs_addr,
  input  logic [REG_AW-1:0]   rt_addr,
  input  logic                wr_en,
  input  logic [REG_AW-1:0]   wr_addr,
  input  logic [WORD_W-1:0]   wr_data,
  output logic [WORD_W-1:0]   data_a,
  output logic [WORD_W-1:0]   data_b,
  output logic                rd_valid,
  output logic [WR_CNT_W-1:0] wr_count
);

  word_t   regs_q [NREGS];
  word_t   regs_d [NREGS];
  word_t   data_a_q, data_a_d;
  word_t   data_b_q, data_b_d;
  logic    rd_valid_q, rd_valid_d;
  wr_req_t wr_req;
  logic    wr_commit;
  word_t   rd_a, rd_b;

  assign wr_req    = '{en: wr_en, addr: wr_addr, data: wr_data};
  assign wr_commit = wr_commits(wr_req);

  // Array next-state: only committed writes touch the array.
  always_comb begin
    regs_d = regs_q;
    if (wr_commit) begin
      regs_d[wr_req.addr] = wr_req.data;
    end
  end

  // Read muxes; $zero is forced so the read never depends on array contents.
  always_comb begin
    rd_a = (rs_addr == REG_ZERO) ? '0 : regs_q[rs_addr];
    rd_b = (rt_addr == REG_ZERO) ? '0 : regs_q[rt_addr];
`ifdef REG_BANK_BYPASS_EN
    if (wr_commit && (wr_req.addr == rs_addr)) begin
      rd_a = wr_req.data;
    end
    if (wr_commit && (wr_req.addr == rt_addr)) begin
      rd_b = wr_req.data;
    end
`endif
  end

  always_comb begin
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    rd_valid_d = rd_en;
    if (rd_en) begin
      data_a_d = rd_a;
      data_b_d = rd_b;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == 32'(REG_SP)) ? SP_RESET : '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_a_q   <= '0;
      data_b_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  reg_bank_wr_counter #(
    .W(WR_CNT_W)
  ) u_wr_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (wr_commit),
    .count   (wr_count)
  );

  assign data_a   = data_a_q;
  assign data_b   = data_b_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard testbench for reg_bank: expected reads queued at drive time, popped on rd_valid.
module tb_reg_bank;
  import cpu_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        rd_en;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        rd_valid;
  logic [15:0] wr_count;

  reg_bank dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_en    (rd_en),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .data_a   (data_a),
    .data_b   (data_b),
    .rd_valid (rd_valid),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] mdl [32];
  logic [15:0] mdl_cnt;
  logic [63:0] exp_q [$];
  logic [31:0] last_a, last_b;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic void mdl_reset();
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    mdl[29] = 32'd227;
    mdl_cnt = 16'd0;
    exp_q.delete();
    last_a = 32'd0;
    last_b = 32'd0;
  endfunction

  function automatic logic [31:0] mdl_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'd0 : mdl[a];
`ifdef REG_BANK_BYPASS_EN
    if (we && (wa == a) && (a != 5'd0)) v = wd;
`endif
    return v;
  endfunction

  // One clock of stimulus; checks rd_valid, wr_count and the read data after the edge.
  task automatic do_cycle(input string tag, input logic re, input logic [4:0] rs,
                          input logic [4:0] rt, input logic we, input logic [4:0] wa,
                          input logic [31:0] wd);
    logic [63:0] e;
    @(negedge clk);
    rd_en = re; rs_addr = rs; rt_addr = rt;
    wr_en = we; wr_addr = wa; wr_data = wd;
    if (re) exp_q.push_back({mdl_read(rs, we, wa, wd), mdl_read(rt, we, wa, wd)});
    @(posedge clk);
    if (we && (wa != 5'd0)) begin
      mdl[wa] = wd;
      mdl_cnt = mdl_cnt + 16'd1;
    end
    #1;
    check_eq({tag, "/rd_valid"}, 32'(rd_valid), 32'(re));
    check_eq({tag, "/wr_count"}, 32'(wr_count), 32'(mdl_cnt));
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        check_eq({tag, "/unexpected_read"}, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        last_a = e[63:32];
        last_b = e[31:0];
        check_eq({tag, "/data_a"}, data_a, last_a);
        check_eq({tag, "/data_b"}, data_b, last_b);
      end
    end else begin
      check_eq({tag, "/hold_a"}, data_a, last_a);
      check_eq({tag, "/hold_b"}, data_b, last_b);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    rd_en = 1'b0; wr_en = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    mdl_reset();
  endtask

  initial begin
    reset_n = 1'b0;
    rd_en = 1'b0; rs_addr = '0; rt_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    mdl_reset();
    #2;
    check_eq("reset/data_a", data_a, 32'd0);
    check_eq("reset/rd_valid", 32'(rd_valid), 32'd0);
    check_eq("reset/wr_count", 32'(wr_count), 32'd0);
    apply_reset();

    do_cycle("sp_reset", 1'b1, 5'd29, 5'd0, 1'b0, 5'd0, 32'd0);
    check_eq("sp_reset/const", data_a, 32'd227);

    do_cycle("wr_ra", 1'b0, 5'd0, 5'd0, 1'b1, 5'd31, 32'h0000_0040);
    do_cycle("rd_ra", 1'b1, 5'd31, 5'd29, 1'b0, 5'd0, 32'd0);
    check_eq("rd_ra/const", data_a, 32'h40);
    do_cycle("hold1", 1'b0, 5'd3, 5'd4, 1'b0, 5'bxxxxx, 32'hFFFF_FFFF);
    do_cycle("hold2", 1'b0, 5'd5, 5'd6, 1'b0, 5'd7, 32'h1234_5678);
    check_eq("hold2/const", data_a, 32'h40);

    do_cycle("wr_zero", 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hDEAD_BEEF);
    do_cycle("rd_zero", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    check_eq("rd_zero/const", data_a, 32'd0);

    do_cycle("wr_r8", 1'b0, 5'd0, 5'd0, 1'b1, 5'd8, 32'd5);
    do_cycle("collide", 1'b1, 5'd8, 5'd8, 1'b1, 5'd8, 32'd9);
`ifdef REG_BANK_BYPASS_EN
    check_eq("collide/const", data_a, 32'd9);
`else
    check_eq("collide/const", data_a, 32'd5);
`endif
    do_cycle("after_collide", 1'b1, 5'd8, 5'd31, 1'b0, 5'd0, 32'd0);
    check_eq("after_collide/const", data_a, 32'd9);

    for (int i = 1; i < 32; i++) begin
      do_cycle("fill", 1'b1, 5'(i - 1), 5'(31 - i), 1'b1, 5'(i), 32'($urandom));
    end
    for (int i = 0; i < 32; i++) begin
      do_cycle("readback", 1'b1, 5'(i), 5'(i), 1'b0, 5'd0, 32'd0);
    end

    apply_reset();
    for (int i = 0; i < 65535; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'(i); rd_en = 1'b0;
      @(posedge clk);
      mdl[1] = 32'(i);
      mdl_cnt = mdl_cnt + 16'd1;
    end
    #1;
    check_eq("preload/wr_count", 32'(wr_count), 32'h0000_FFFF);
    do_cycle("wrap", 1'b1, 5'd1, 5'd29, 1'b1, 5'd1, 32'hCAFE_0001);
    check_eq("wrap/const", 32'(wr_count), 32'd0);

    @(negedge clk);
    rd_en = 1'b1; rs_addr = 5'd29; wr_en = 1'b1; wr_addr = 5'd29; wr_data = 32'hABCD_0000;
    #4 reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midreset/wr_count", 32'(wr_count), 32'd0);
    check_eq("midreset/data_a", data_a, 32'd0);
    check_eq("midreset/rd_valid", 32'(rd_valid), 32'd0);
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
    reset_n = 1'b1;
    mdl_reset();
    do_cycle("midreset_sp", 1'b1, 5'd29, 5'd29, 1'b0, 5'd0, 32'd0);
    check_eq("midreset_sp/const", data_a, 32'd227);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
